lcd_nibble_writer: RTL and testbench

// Downstream display stage: takes bytes from the register-display datapath and drives an
// HD44780-compatible character LCD in 4-bit mode (data nibbles, RS, RW, E strobe).

---
 rtl/lcd_nibble_writer.sv | 218 +++++++++++++++++++++
 tb/tb_lcd_nibble_writer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: drives an HD44780-compatible LCD in 4-bit write-only mode.
// Runs the power-up init sequence, then serialises one byte per valid/ready
// handshake as two timed nibble writes followed by a settle wait.
module lcd_nibble_writer #(
    parameter int unsigned POWERUP_CYC    = 750000,
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned E_HIGH_CYC     = 12,
    parameter int unsigned HOLD_CYC       = 2,
    parameter int unsigned CMD_WAIT_CYC   = 2500,
    parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_rs,
    output logic       in_ready,
    output logic       init_done,
    output logic       busy,
    output logic [3:0] lcd_d,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    localparam int unsigned NIB_CYC = SETUP_CYC + E_HIGH_CYC + HOLD_CYC;
    localparam int unsigned MAX_A   = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
    localparam int unsigned MAX_B   = (NIB_CYC > CMD_WAIT_CYC) ? NIB_CYC : CMD_WAIT_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] NIB_LAST = CNT_W'(NIB_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);
    // One extra bit so the E-window end can equal NIB_CYC when HOLD_CYC is 0.
    localparam logic [CNT_W:0]   E_ON_C   = (CNT_W+1)'(SETUP_CYC);
    localparam logic [CNT_W:0]   E_OFF_C  = (CNT_W+1)'(SETUP_CYC + E_HIGH_CYC);

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT_NIB,
        ST_INIT_WAIT,
        ST_INIT_BYTE,
        ST_IDLE,
        ST_XFER,
        ST_WAIT
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_init_idx;
    logic [1:0]       r_byte_idx;
    logic [7:0]       r_byte;
    logic             r_byte_rs;
    logic             r_nib_lo;
    logic             r_wait_clr;
    logic             r_ready;
    logic             r_done;
    logic             r_busy;
    logic [3:0]       r_d;
    logic             r_rs;
    logic             r_rw;
    logic             r_en;

    logic [CNT_W:0]   w_cnt_inc;
    logic             w_en_next;
    logic             w_nib_last;
    logic             w_wait_last;
    logic [3:0]       w_init_nib_next;
    logic [7:0]       w_init_byte;
    logic             w_is_clr;

    // Counter helpers, E window for the following cycle and init table lookups.
    always_comb begin
        w_cnt_inc       = {1'b0, r_cnt} + (CNT_W+1)'(1);
        w_en_next       = (w_cnt_inc >= E_ON_C) && (w_cnt_inc < E_OFF_C);
        w_nib_last      = (r_cnt == NIB_LAST);
        w_wait_last     = (r_cnt == (r_wait_clr ? CLR_LAST : CMD_LAST));
        w_init_nib_next = (r_init_idx == 2'd2) ? 4'h2 : 4'h3;
        w_is_clr        = !r_byte_rs && ((r_byte == 8'h01) || (r_byte == 8'h02));
        w_init_byte     = 8'h28;
        case (r_byte_idx)
            2'd0:    w_init_byte = 8'h28;
            2'd1:    w_init_byte = 8'h0C;
            2'd2:    w_init_byte = 8'h06;
            default: w_init_byte = 8'h01;
        endcase
    end

    // Main FSM; every LCD/handshake output is registered and reflects the state of the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_PWR_WAIT;
            r_cnt      <= '0;
            r_init_idx <= '0;
            r_byte_idx <= '0;
            r_byte     <= '0;
            r_byte_rs  <= 1'b0;
            r_nib_lo   <= 1'b0;
            r_wait_clr <= 1'b0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_d        <= '0;
            r_rs       <= 1'b0;
            r_rw       <= 1'b0;
            r_en       <= 1'b0;
        end else begin
            r_rw <= 1'b0;
            case (r_state)
                ST_PWR_WAIT: begin
                    if (r_cnt == PWR_LAST) begin
                        r_cnt   <= '0;
                        r_d     <= 4'h3;
                        r_rs    <= 1'b0;
                        r_en    <= 1'b0;
                        r_state <= ST_INIT_NIB;
                    end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                    end
                end
                ST_INIT_NIB: begin
                    if (w_nib_last) begin
                        r_cnt   <= '0;
                        r_en    <= 1'b0;
                        r_state <= ST_INIT_WAIT;
                    end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                        r_en  <= w_en_next;
                    end
                end
                ST_INIT_WAIT: begin
                    if (r_cnt == CMD_LAST) begin
                        r_cnt <= '0;
                        if (r_init_idx == 2'd3) begin
                            r_state <= ST_INIT_BYTE;
                        end else begin
                            r_init_idx <= r_init_idx + 2'd1;
                            r_d        <= w_init_nib_next;
                            r_state    <= ST_INIT_NIB;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                    end
                end
                ST_INIT_BYTE: begin
                    r_byte    <= w_init_byte;
                    r_byte_rs <= 1'b0;
                    r_d       <= w_init_byte[7:4];
                    r_rs      <= 1'b0;
                    r_nib_lo  <= 1'b0;
                    r_cnt     <= '0;
                    r_state   <= ST_XFER;
                end
                ST_IDLE: begin
                    r_en <= 1'b0;
                    if (in_valid && r_ready) begin
                        r_byte    <= in_data;
                        r_byte_rs <= in_rs;
                        r_d       <= in_data[7:4];
                        r_rs      <= in_rs;
                        r_nib_lo  <= 1'b0;
                        r_cnt     <= '0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_nib_last) begin
                        r_cnt <= '0;
                        r_en  <= 1'b0;
                        if (!r_nib_lo) begin
                            r_nib_lo <= 1'b1;
                            r_d      <= r_byte[3:0];
                        end else begin
                            r_wait_clr <= w_is_clr;
                            r_state    <= ST_WAIT;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                        r_en  <= w_en_next;
                    end
                end
                ST_WAIT: begin
                    if (w_wait_last) begin
                        r_cnt <= '0;
                        if (r_done || (r_byte_idx == 2'd3)) begin
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_state    <= ST_INIT_BYTE;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                    end
                end
                default: begin
                    r_state <= ST_PWR_WAIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign in_ready  = r_ready;
    assign init_done = r_done;
    assign busy      = r_busy;
    assign lcd_d     = r_d;
    assign lcd_rs    = r_rs;
    assign lcd_rw    = r_rw;
    assign lcd_en    = r_en;

endmodule

// File: tb/tb_lcd_nibble_writer.sv
// Directed bench for lcd_nibble_writer with shortened timing (N = 4).
module tb_lcd_nibble_writer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_rs;
    logic       in_ready;
    logic       init_done;
    logic       busy;
    logic [3:0] lcd_d;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;

    int total = 0;
    int bad   = 0;

    lcd_nibble_writer #(
        .POWERUP_CYC   (20),
        .SETUP_CYC     (1),
        .E_HIGH_CYC    (2),
        .HOLD_CYC      (1),
        .CMD_WAIT_CYC  (5),
        .CLEAR_WAIT_CYC(15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_rs    (in_rs),
        .in_ready (in_ready),
        .init_done(init_done),
        .busy     (busy),
        .lcd_d    (lcd_d),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_en   (lcd_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: logs {rs,d} at each E rise and checks strobe shape.
    logic [4:0] pulses[$];
    int         cyc = 0;
    int         hi_cnt = 0;
    int         last_fall = 0;
    int         done_rise = 0;
    logic       m_prev_en = 1'b0;
    logic       m_prev_done = 1'b0;
    logic [3:0] m_prev_d = '0;
    logic       m_prev_rs = 1'b0;
    logic [3:0] m_pd = '0;
    logic       m_prs = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            hi_cnt      = 0;
            m_prev_en   = 1'b0;
            m_prev_done = 1'b0;
        end else begin
            if (lcd_en && !m_prev_en) begin
                check("setup_stable", {27'd0, lcd_rs, lcd_d}, {27'd0, m_prev_rs, m_prev_d});
                check("rw_zero", {31'd0, lcd_rw}, 32'd0);
                pulses.push_back({lcd_rs, lcd_d});
                m_pd   = lcd_d;
                m_prs  = lcd_rs;
                hi_cnt = 1;
            end else if (lcd_en) begin
                hi_cnt++;
                check("high_stable", {27'd0, lcd_rs, lcd_d}, {27'd0, m_prs, m_pd});
            end else if (m_prev_en) begin
                check("e_high_len", hi_cnt, 2);
                check("hold_stable", {27'd0, lcd_rs, lcd_d}, {27'd0, m_prs, m_pd});
                last_fall = cyc;
            end
            if (init_done && !m_prev_done) done_rise = cyc;
            m_prev_en   = lcd_en;
            m_prev_done = init_done;
        end
        m_prev_d  = lcd_d;
        m_prev_rs = lcd_rs;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!init_done && n < 3000) begin
            tick();
            n++;
        end
    endtask

    // Counts edges after an accepting edge until in_ready is high again.
    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 500) begin
            tick();
            n++;
        end
    endtask

    task automatic check_init_pulses(input string tag);
        logic [4:0] exp[12];
        exp = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08, 5'h00, 5'h0C, 5'h00, 5'h06, 5'h00, 5'h01};
        check({tag, "_count"}, pulses.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < pulses.size())
                check($sformatf("%s_p%0d", tag, i), {27'd0, pulses[i]}, {27'd0, exp[i]});
        end
    endtask

    // Drives one byte, waits for it to be accepted, returns latency back to ready.
    task automatic send_byte(input logic [7:0] d, input logic rs, output int lat);
        in_valid = 1'b1;
        in_data  = d;
        in_rs    = rs;
        tick();
        in_valid = 1'b0;
        in_data  = 8'hFF;
        in_rs    = ~rs;
        check("ready_drop", {31'd0, in_ready}, 32'd0);
        wait_ready(lat);
    endtask

    int n;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_rs    = 1'b0;
        repeat (3) tick();
        check("rst_en", {31'd0, lcd_en}, 32'd0);
        check("rst_d", {28'd0, lcd_d}, 32'd0);
        check("rst_rs", {31'd0, lcd_rs}, 32'd0);
        check("rst_rw", {31'd0, lcd_rw}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_done", {31'd0, init_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        pulses.delete();
        rst = 1'b0;

        // Init sequence.
        wait_done(n);
        check("init_done_seen", {31'd0, init_done}, 32'd1);
        tick();
        check_init_pulses("init");
        check("done_after_hold", done_rise - last_fall, 16);
        check("idle_ready", {31'd0, in_ready}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_en", {31'd0, lcd_en}, 32'd0);

        // Data byte 0x41.
        pulses.delete();
        send_byte(8'h41, 1'b1, n);
        check("lat_41", n, 13);
        check("p41_count", pulses.size(), 2);
        if (pulses.size() == 2) begin
            check("p41_hi", {27'd0, pulses[0]}, 32'h14);
            check("p41_lo", {27'd0, pulses[1]}, 32'h11);
        end
        check("idle_keeps_d", {28'd0, lcd_d}, 32'h1);

        // Clear command and a plain command.
        send_byte(8'h01, 1'b0, n);
        check("lat_clr", n, 23);
        send_byte(8'h02, 1'b0, n);
        check("lat_home", n, 23);
        send_byte(8'h80, 1'b0, n);
        check("lat_80", n, 13);
        send_byte(8'h01, 1'b1, n);
        check("lat_data01", n, 13);

        // Back-to-back with in_valid held and inputs changing mid-transfer.
        pulses.delete();
        in_valid = 1'b1;
        in_data  = 8'h48;
        in_rs    = 1'b1;
        tick();
        check("b2b_drop1", {31'd0, in_ready}, 32'd0);
        in_data = 8'h49;
        wait_ready(n);
        check("b2b_lat1", n, 13);
        tick();
        check("b2b_drop2", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        in_data  = 8'hF0;
        in_rs    = 1'b0;
        wait_ready(n);
        check("b2b_lat2", n, 13);
        check("b2b_count", pulses.size(), 4);
        if (pulses.size() == 4) begin
            check("b2b_p0", {27'd0, pulses[0]}, 32'h14);
            check("b2b_p1", {27'd0, pulses[1]}, 32'h18);
            check("b2b_p2", {27'd0, pulses[2]}, 32'h14);
            check("b2b_p3", {27'd0, pulses[3]}, 32'h19);
        end

        // Reset while E is high.
        in_valid = 1'b1;
        in_data  = 8'h41;
        in_rs    = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!lcd_en && n < 50) begin
            tick();
            n++;
        end
        check("e_seen_before_rst", {31'd0, lcd_en}, 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_en", {31'd0, lcd_en}, 32'd0);
        check("mid_rst_done", {31'd0, init_done}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd1);
        tick();
        pulses.delete();
        rst = 1'b0;
        wait_done(n);
        check("reinit_done", {31'd0, init_done}, 32'd1);
        tick();
        check_init_pulses("reinit");
        check("redone_after_hold", done_rise - last_fall, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
